// File: rtl/usb_tx_sched.sv
// usb_tx_sched: fixed-priority arbiter and bit serialiser for USB handshake, token and
// data packets; emits SYNC, LSB-first payload and an idle inter-packet gap per packet.
`timescale 1ns/1ps
module usb_tx_sched #(
  parameter int unsigned IPG = 2
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        hs_req,
  input  logic [7:0]  hs_pid,
  input  logic        tok_req,
  input  logic [23:0] tok_bits,
  input  logic        dat_req,
  input  logic [87:0] dat_bits,
  output logic        hs_gnt,
  output logic        tok_gnt,
  output logic        dat_gnt,
  output logic        bstr_out,
  output logic [1:0]  bstr_out_ready,
  output logic        busy,
  output logic        pkt_done
);

  localparam int unsigned SHIFT_W = 88;
  localparam int unsigned CNT_W   = 7;
  localparam int unsigned TAG_W   = 2;
  localparam int unsigned HS_W    = 8;
  localparam int unsigned TOK_W   = 24;

  localparam logic [CNT_W-1:0] HS_LEN    = CNT_W'(HS_W);
  localparam logic [CNT_W-1:0] TOK_LEN   = CNT_W'(TOK_W);
  localparam logic [CNT_W-1:0] DAT_LEN   = CNT_W'(SHIFT_W);
  localparam logic [CNT_W-1:0] SYNC_LOAD = CNT_W'(7);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(IPG - 1);

  localparam logic [TAG_W-1:0] TAG_IDLE = 2'b00;
  localparam logic [TAG_W-1:0] TAG_TOK  = 2'b01;
  localparam logic [TAG_W-1:0] TAG_DAT  = 2'b10;
  localparam logic [TAG_W-1:0] TAG_HS   = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    PAYLOAD = 2'd2,
    GAP     = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SHIFT_W-1:0] sreg_q, sreg_d;
  logic [TAG_W-1:0]   type_q, type_d;
  logic [CNT_W-1:0]   len_q, len_d;

  logic               hs_gnt_d;
  logic               tok_gnt_d;
  logic               dat_gnt_d;
  logic               bit_d;
  logic [TAG_W-1:0]   tag_d;
  logic               busy_d;
  logic               done_d;

  // State register plus registered outputs
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      sreg_q         <= '0;
      type_q         <= TAG_IDLE;
      len_q          <= '0;
      hs_gnt         <= 1'b0;
      tok_gnt        <= 1'b0;
      dat_gnt        <= 1'b0;
      bstr_out       <= 1'b1;
      bstr_out_ready <= TAG_IDLE;
      busy           <= 1'b0;
      pkt_done       <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sreg_q         <= sreg_d;
      type_q         <= type_d;
      len_q          <= len_d;
      hs_gnt         <= hs_gnt_d;
      tok_gnt        <= tok_gnt_d;
      dat_gnt        <= dat_gnt_d;
      bstr_out       <= bit_d;
      bstr_out_ready <= tag_d;
      busy           <= busy_d;
      pkt_done       <= done_d;
    end
  end

  // Next state, counter, shift register and the output values for the state being entered
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sreg_d    = sreg_q;
    type_d    = type_q;
    len_d     = len_q;
    hs_gnt_d  = 1'b0;
    tok_gnt_d = 1'b0;
    dat_gnt_d = 1'b0;
    bit_d     = 1'b1;
    tag_d     = TAG_IDLE;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (hs_req) begin
          hs_gnt_d = 1'b1;
          type_d   = TAG_HS;
          len_d    = HS_LEN;
          sreg_d   = {(SHIFT_W - HS_W)'(0), hs_pid};
          state_d  = SYNC;
          cnt_d    = SYNC_LOAD;
        end else if (tok_req) begin
          tok_gnt_d = 1'b1;
          type_d    = TAG_TOK;
          len_d     = TOK_LEN;
          sreg_d    = {(SHIFT_W - TOK_W)'(0), tok_bits};
          state_d   = SYNC;
          cnt_d     = SYNC_LOAD;
        end else if (dat_req) begin
          dat_gnt_d = 1'b1;
          type_d    = TAG_DAT;
          len_d     = DAT_LEN;
          sreg_d    = dat_bits;
          state_d   = SYNC;
          cnt_d     = SYNC_LOAD;
        end
      end
      SYNC: begin
        if (cnt_q == '0) begin
          state_d = PAYLOAD;
          cnt_d   = len_q - CNT_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PAYLOAD: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // The SYNC pattern ends in a single 1 on its final count; payload leaves LSB first
    unique case (state_d)
      SYNC: begin
        bit_d = (cnt_d == '0);
        tag_d = type_d;
      end
      PAYLOAD: begin
        bit_d  = sreg_q[0];
        sreg_d = sreg_q >> 1;
        tag_d  = type_d;
      end
      default: begin
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_usb_tx_sched.sv
// Self-checking bench for usb_tx_sched: a packet-level model predicts every output cycle,
// plus directed checks on grant spacing, reset abort and a second instance with IPG=1.
`timescale 1ns/1ps
module tb_usb_tx_sched;

  localparam int unsigned IPG = 2;
  localparam logic [7:0]  IDLE_E = 8'b0001_0000;  // {gnt3, bit, tag2, busy, done}

  logic        clk = 1'b0;
  logic        rst_b;
  logic        hs_req, tok_req, dat_req;
  logic [7:0]  hs_pid;
  logic [23:0] tok_bits;
  logic [87:0] dat_bits;
  logic        hs_gnt, tok_gnt, dat_gnt, bstr_out, busy, pkt_done;
  logic [1:0]  bstr_out_ready;

  logic        hs_req1, tok_req1, dat_req1;
  logic [7:0]  hs_pid1;
  logic [23:0] tok_bits1;
  logic [87:0] dat_bits1;
  logic        hs_gnt1, tok_gnt1, dat_gnt1, bstr_out1, busy1, pkt_done1;
  logic [1:0]  bstr_out_ready1;

  logic [7:0]  outv;
  logic [7:0]  outv1;
  assign outv  = {hs_gnt, tok_gnt, dat_gnt, bstr_out, bstr_out_ready, busy, pkt_done};
  assign outv1 = {hs_gnt1, tok_gnt1, dat_gnt1, bstr_out1, bstr_out_ready1, busy1, pkt_done1};

  usb_tx_sched #(.IPG(IPG)) dut (
    .clk(clk), .rst_b(rst_b),
    .hs_req(hs_req), .hs_pid(hs_pid),
    .tok_req(tok_req), .tok_bits(tok_bits),
    .dat_req(dat_req), .dat_bits(dat_bits),
    .hs_gnt(hs_gnt), .tok_gnt(tok_gnt), .dat_gnt(dat_gnt),
    .bstr_out(bstr_out), .bstr_out_ready(bstr_out_ready),
    .busy(busy), .pkt_done(pkt_done)
  );

  usb_tx_sched #(.IPG(1)) dut1 (
    .clk(clk), .rst_b(rst_b),
    .hs_req(hs_req1), .hs_pid(hs_pid1),
    .tok_req(tok_req1), .tok_bits(tok_bits1),
    .dat_req(dat_req1), .dat_bits(dat_bits1),
    .hs_gnt(hs_gnt1), .tok_gnt(tok_gnt1), .dat_gnt(dat_gnt1),
    .bstr_out(bstr_out1), .bstr_out_ready(bstr_out_ready1),
    .busy(busy1), .pkt_done(pkt_done1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int hs_t, tok_t, dat_t, done_t;
  int tag_cnt, tag_ones;
  logic [7:0] expq[$];
  logic prev_idle = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected output symbols of one packet: 8 SYNC, len payload bits, IPG gap cycles
  task automatic push_pkt(input logic [2:0] g, input logic [1:0] ty, input logic [87:0] p,
                          input int len);
    for (int i = 0; i < 8; i++)
      expq.push_back({(i == 0) ? g : 3'b000, (i == 7), ty, 1'b1, 1'b0});
    for (int i = 0; i < len; i++)
      expq.push_back({3'b000, p[i], ty, 1'b1, 1'b0});
    for (int i = 0; i < int'(IPG); i++)
      expq.push_back({3'b000, 1'b1, 2'b00, 1'b1, (i == 0)});
  endtask

  // One clock: advance the model on the edge, then compare all outputs 1 ns later
  task automatic tick();
    logic [7:0] e;
    @(posedge clk);
    cyc++;
    if (!rst_b) begin
      expq.delete();
      e = IDLE_E;
    end else begin
      if (prev_idle) begin
        if (hs_req)       push_pkt(3'b100, 2'b11, {80'd0, hs_pid}, 8);
        else if (tok_req) push_pkt(3'b010, 2'b01, {64'd0, tok_bits}, 24);
        else if (dat_req) push_pkt(3'b001, 2'b10, dat_bits, 88);
      end
      if (expq.size() > 0) e = expq.pop_front();
      else                 e = IDLE_E;
    end
    prev_idle = !e[1];
    #1;
    check("cycle_out", 32'(outv), 32'(e));
    if (hs_gnt)   hs_t = cyc;
    if (tok_gnt)  tok_t = cyc;
    if (dat_gnt)  dat_t = cyc;
    if (pkt_done) done_t = cyc;
    if (bstr_out_ready != 2'b00) begin
      tag_cnt++;
      if (bstr_out) tag_ones++;
    end
  endtask

  task automatic wait_gnt(input int which, input string tag);
    int  n = 0;
    logic seen = 1'b0;
    while (!seen && n < 300) begin
      tick();
      n++;
      seen = outv[7-which];
    end
    check(tag, 32'(seen), 32'(1));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((expq.size() != 0 || !prev_idle) && n < 400) begin
      tick();
      n++;
    end
    tick();
    check(tag, 32'(busy), 32'(0));
  endtask

  task automatic rand_drive(input logic allow_new);
    if (hs_gnt)  hs_req  = 1'b0;
    if (tok_gnt) tok_req = 1'b0;
    if (dat_gnt) dat_req = 1'b0;
    hs_pid   = 8'($urandom);
    tok_bits = 24'($urandom);
    dat_bits = {24'($urandom), $urandom, $urandom};
    if (allow_new) begin
      if (!hs_req  && $urandom_range(0, 15) == 0) hs_req  = 1'b1;
      if (!tok_req && $urandom_range(0, 15) == 0) tok_req = 1'b1;
      if (!dat_req && $urandom_range(0, 15) == 0) dat_req = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [87:0] top_bit;
    int g1, g2, zc, d1, n;
    rst_b = 1'b0;
    hs_req = 0; tok_req = 0; dat_req = 0;
    hs_pid = 0; tok_bits = 0; dat_bits = 0;
    hs_req1 = 0; tok_req1 = 0; dat_req1 = 0;
    hs_pid1 = 0; tok_bits1 = 0; dat_bits1 = 0;
    tag_cnt = 0; tag_ones = 0;

    // Reset state
    repeat (3) tick();
    rst_b = 1'b1;
    repeat (2) tick();

    // Single handshake, PID 0xD2
    hs_pid = 8'hD2;
    hs_req = 1'b1;
    wait_gnt(0, "hs_single_gnt");
    hs_req = 1'b0;
    hs_pid = 8'($urandom);
    wait_idle("hs_single_idle");
    check("hs_done_offset", 32'(done_t - hs_t), 32'(16));

    // Single token 0x2A5C69
    tok_bits = 24'h2A5C69;
    tok_req  = 1'b1;
    tag_cnt  = 0;
    wait_gnt(1, "tok_single_gnt");
    tok_req  = 1'b0;
    tok_bits = 24'($urandom);
    wait_idle("tok_single_idle");
    check("tok_done_offset", 32'(done_t - tok_t), 32'(32));
    check("tok_tagged", 32'(tag_cnt), 32'(32));

    // Simultaneous requests
    hs_pid = 8'($urandom); tok_bits = 24'($urandom);
    dat_bits = {24'($urandom), $urandom, $urandom};
    hs_req = 1; tok_req = 1; dat_req = 1;
    wait_gnt(0, "all_hs_gnt");  hs_req = 0;
    wait_gnt(1, "all_tok_gnt"); tok_req = 0;
    wait_gnt(2, "all_dat_gnt"); dat_req = 0;
    wait_idle("all_idle");
    check("space_hs_tok", 32'(tok_t - hs_t), 32'(17 + IPG));
    check("space_tok_dat", 32'(dat_t - tok_t), 32'(33 + IPG));

    // Data packet with only the top payload bit set
    top_bit = 88'h1;
    top_bit = top_bit << 87;
    dat_bits = top_bit;
    dat_req  = 1'b1;
    tag_cnt = 0; tag_ones = 0;
    wait_gnt(2, "dat_top_gnt");
    dat_req  = 1'b0;
    dat_bits = {24'($urandom), $urandom, $urandom};
    wait_idle("dat_top_idle");
    check("dat_top_tagged", 32'(tag_cnt), 32'(96));
    check("dat_top_ones", 32'(tag_ones), 32'(2));

    // Reset in the middle of a data packet, at payload bit 40
    dat_bits = {24'($urandom), $urandom, $urandom};
    dat_req  = 1'b1;
    wait_gnt(2, "rst_dat_gnt");
    repeat (48) tick();
    done_t = 0;
    rst_b = 1'b0;
    #1;
    check("rst_async_out", 32'(outv), 32'(IDLE_E));
    expq.delete();
    prev_idle = 1'b1;
    repeat (2) tick();
    rst_b = 1'b1;
    tick();
    check("rst_regrant", 32'(dat_gnt), 32'(1));
    check("rst_no_done", 32'(done_t), 32'(0));
    dat_req = 1'b0;
    wait_idle("rst_idle");

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      tick();
      rand_drive(1'b1);
    end
    n = 0;
    while ((hs_req || tok_req || dat_req) && n < 400) begin
      tick();
      rand_drive(1'b0);
      n++;
    end
    check("rand_drained", 32'(hs_req || tok_req || dat_req), 32'(0));
    wait_idle("rand_idle");

    // IPG=1 instance, back-to-back tokens
    tok_bits1 = 24'($urandom);
    tok_req1  = 1'b1;
    g1 = -1; g2 = -1; zc = 0; d1 = -1;
    for (int i = 0; i < 200 && g2 < 0; i++) begin
      tick();
      if (tok_gnt1) begin
        if (g1 < 0) g1 = cyc;
        else        g2 = cyc;
      end else if (g1 >= 0 && bstr_out_ready1 == 2'b00) begin
        zc++;
      end
      if (pkt_done1 && d1 < 0) d1 = cyc;
    end
    tok_req1 = 1'b0;
    check("ipg1_first_gnt", 32'(g1 >= 0), 32'(1));
    check("ipg1_spacing", 32'(g2 - g1), 32'(34));
    check("ipg1_idle_tags", 32'(zc), 32'(2));
    check("ipg1_done_offset", 32'(d1 - g1), 32'(32));
    repeat (40) tick();
    check("ipg1_idle_end", 32'(outv1), 32'(IDLE_E));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
